// File: rtl/nn_input_framer_if.sv
// Sample-in / frame-out handshake bundle for the NN input framer.
// The slave modport is the framer's view; master is the producer/consumer side.
interface nn_input_framer_if #(
  parameter int DW  = 10,
  parameter int NIN = 12
);
  logic [DW-1:0]     s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DW*NIN-1:0] frame_data;
  logic              frame_valid;
  logic              frame_ready;

  modport slave (
    input  s_data, s_valid, frame_ready,
    output s_ready, frame_data, frame_valid
  );

  modport master (
    output s_data, s_valid, frame_ready,
    input  s_ready, frame_data, frame_valid
  );
endinterface

// File: rtl/nn_input_framer.sv
// Sliding-window framer: shifts 10-bit samples into an NIN-tap window and
// publishes a held snapshot every STRIDE accepted samples once the window is full.
module nn_input_framer #(
  parameter int DW     = 10,
  parameter int NIN    = 12,
  parameter int STRIDE = 1,
  parameter int CW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  nn_input_framer_if.slave    bus,
  output logic [3:0]          fill,
  output logic [CW-1:0]       frame_cnt
);
  localparam int SCW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [SCW-1:0] STRIDE_LAST = SCW'(STRIDE - 1);
  localparam logic [3:0]     NIN_F       = 4'(NIN);

  logic [DW*NIN-1:0] win_q, win_d, win_shift;
  logic [DW*NIN-1:0] frame_q, frame_d;
  logic              fvalid_q, fvalid_d;
  logic [3:0]        fill_q, fill_d, fill_next;
  logic [SCW-1:0]    scnt_q, scnt_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic              emit_next, s_ready, accept, emit;

  always_comb begin
    fill_next = (fill_q == NIN_F) ? fill_q : fill_q + 4'd1;
    emit_next = (fill_next == NIN_F) && (scnt_q == STRIDE_LAST);
    // Only a sample that would overwrite an unconsumed frame is stalled.
    s_ready   = !flush && !(fvalid_q && !bus.frame_ready && emit_next);
    accept    = bus.s_valid && s_ready;
    emit      = accept && emit_next;
    win_shift = {win_q[DW*(NIN-1)-1:0], bus.s_data};

    win_d    = win_q;
    fill_d   = fill_q;
    scnt_d   = scnt_q;
    frame_d  = frame_q;
    fvalid_d = fvalid_q;
    fcnt_d   = fcnt_q;

    if (flush) begin
      win_d  = '0;
      fill_d = '0;
      scnt_d = STRIDE_LAST;
    end else if (accept) begin
      win_d  = win_shift;
      fill_d = fill_next;
      // Parked at STRIDE_LAST while filling so the filling sample emits.
      if (fill_next == NIN_F)
        scnt_d = (scnt_q == STRIDE_LAST) ? '0 : scnt_q + 1'b1;
      else
        scnt_d = STRIDE_LAST;
    end

    if (emit) begin
      frame_d  = win_shift;
      fvalid_d = 1'b1;
      fcnt_d   = fcnt_q + 1'b1;
    end else if (fvalid_q && bus.frame_ready) begin
      fvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q    <= '0;
      frame_q  <= '0;
      fvalid_q <= 1'b0;
      fill_q   <= '0;
      scnt_q   <= '0;
      fcnt_q   <= '0;
    end else begin
      win_q    <= win_d;
      frame_q  <= frame_d;
      fvalid_q <= fvalid_d;
      fill_q   <= fill_d;
      scnt_q   <= scnt_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = fvalid_q;
  assign fill            = fill_q;
  assign frame_cnt       = fcnt_q;
endmodule
